// File: rtl/char_pkg.sv
// Shared character codes, the character type and the sequencer state encoding.
// The buffer, the sequencer and the glyph drawer all import this package.
package char_pkg;

    typedef logic [5:0] char_t;

    localparam char_t CODE_SPACE   = 6'd0;
    localparam char_t CODE_NEWLINE = 6'd62;
    localparam char_t CODE_EOT     = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_OFFER,
        ST_WAIT,
        ST_ADVANCE,
        ST_NEXT,
        ST_FINISH
    } state_t;

    function automatic logic is_printable(input char_t c);
        return (c != CODE_SPACE) && (c != CODE_NEWLINE) && (c != CODE_EOT);
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Column/row text cursor with automatic line wrap and a sticky page-overflow flag.
module text_cursor #(
    parameter int CHARS_PER_LINE = 16,
    parameter int LINES          = 8,
    parameter int COL_W          = 4,
    parameter int ROW_W          = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic             newline,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             overflow
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(CHARS_PER_LINE - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LINES - 1);

    logic line_break;

    always_comb begin
        line_break = newline || (advance && (col == LAST_COL));
    end

    // The row never wraps: a break on the last row only raises overflow.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            col      <= '0;
            row      <= '0;
            overflow <= 1'b0;
        end else if (line_break) begin
            col <= '0;
            if (row == LAST_ROW)
                overflow <= 1'b1;
            else
                row <= row + 1'b1;
        end else if (advance) begin
            col <= col + 1'b1;
        end
    end

endmodule

// File: rtl/char_sequencer.sv
// Walks the character buffer, tracks the text cursor and hands printable
// codes to the glyph drawer over a valid/ready handshake.
module char_sequencer
    import char_pkg::*;
#(
    parameter int BUF_DEPTH      = 100,
    parameter int CHARS_PER_LINE = 16,
    parameter int LINES          = 8,
    parameter int COL_W          = 4,
    parameter int ROW_W          = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       char_count,
    input  logic [5:0]       curr_char,
    output logic [6:0]       select,
    output logic [5:0]       glyph_code,
    output logic [COL_W-1:0] glyph_col,
    output logic [ROW_W-1:0] glyph_row,
    output logic             glyph_valid,
    input  logic             glyph_ready,
    input  logic             draw_done,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    state_t           state;
    char_t            ch;
    logic [6:0]       limit;
    logic [6:0]       sel_next;
    logic             cur_clear;
    logic             cur_advance;
    logic             cur_newline;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             cur_overflow;

    always_comb begin
        limit       = (char_count > 7'(BUF_DEPTH)) ? 7'(BUF_DEPTH) : char_count;
        sel_next    = select + 7'd1;
        cur_clear   = (state == ST_IDLE) && start;
        cur_advance = (state == ST_ADVANCE);
        cur_newline = (state == ST_DECODE) && (ch == CODE_NEWLINE);
    end

    text_cursor #(
        .CHARS_PER_LINE (CHARS_PER_LINE),
        .LINES          (LINES),
        .COL_W          (COL_W),
        .ROW_W          (ROW_W)
    ) u_cursor (
        .clock    (clock),
        .reset    (reset),
        .clear    (cur_clear),
        .advance  (cur_advance),
        .newline  (cur_newline),
        .col      (cur_col),
        .row      (cur_row),
        .overflow (cur_overflow)
    );

    // done is raised by FINISH and so appears on the cycle after it; busy is
    // held through that cycle so both drop together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            ch          <= '0;
            select      <= '0;
            glyph_code  <= '0;
            glyph_col   <= '0;
            glyph_row   <= '0;
            glyph_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        select   <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (limit == 7'd0) ? ST_FINISH : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ch    <= curr_char;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (ch == CODE_EOT) begin
                        state <= ST_FINISH;
                    end else if (ch == CODE_SPACE) begin
                        state <= ST_ADVANCE;
                    end else if (ch == CODE_NEWLINE) begin
                        state <= ST_NEXT;
                    end else begin
                        glyph_code  <= ch;
                        glyph_col   <= cur_col;
                        glyph_row   <= cur_row;
                        glyph_valid <= 1'b1;
                        state       <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (glyph_ready) begin
                        glyph_valid <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (draw_done)
                        state <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (cur_overflow) begin
                        overflow <= 1'b1;
                        state    <= ST_FINISH;
                    end else if (sel_next >= limit) begin
                        state <= ST_FINISH;
                    end else begin
                        select <= sel_next;
                        state  <= ST_FETCH;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_sequencer.sv
// Directed bench for char_sequencer with a behavioural buffer and glyph drawer.
module tb_char_sequencer;

    logic       clock;
    logic       reset;
    logic       start;
    logic [6:0] char_count;
    logic [5:0] curr_char;
    logic [6:0] select;
    logic [5:0] glyph_code;
    logic [3:0] glyph_col;
    logic [2:0] glyph_row;
    logic       glyph_valid;
    logic       glyph_ready;
    logic       draw_done;
    logic       busy;
    logic       done;
    logic       overflow;

    logic [5:0]  mem [0:127];
    logic [12:0] accepted [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stray_req = 0;
    int          stray_ack = 0;
    int          dd_cnt = 0;

    char_sequencer #(
        .BUF_DEPTH      (100),
        .CHARS_PER_LINE (16),
        .LINES          (8),
        .COL_W          (4),
        .ROW_W          (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .char_count  (char_count),
        .curr_char   (curr_char),
        .select      (select),
        .glyph_code  (glyph_code),
        .glyph_col   (glyph_col),
        .glyph_row   (glyph_row),
        .glyph_valid (glyph_valid),
        .glyph_ready (glyph_ready),
        .draw_done   (draw_done),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    assign curr_char = mem[select];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drawer: logs each accepted glyph and pulses draw_done two cycles later.
    initial begin
        draw_done = 1'b0;
        forever begin
            @(negedge clock);
            draw_done = 1'b0;
            if (dd_cnt > 0) begin
                dd_cnt--;
                if (dd_cnt == 0)
                    draw_done = 1'b1;
            end
            if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                draw_done = 1'b1;
            end
            if (glyph_valid && glyph_ready && !reset) begin
                accepted.push_back({glyph_code, glyph_col, glyph_row});
                dd_cnt = 2;
            end
        end
    end

    function automatic logic [12:0] glyph(input int code, input int col, input int row);
        return {6'(code), 4'(col), 3'(row)};
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++)
            mem[i] = 6'd63;
        accepted.delete();
    endtask

    task automatic pulse_start(input int count);
        char_count = 7'(count);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check_val({tag, "_done"}, int'(done), 1);
    endtask

    initial begin
        int stable;
        reset       = 1'b1;
        start       = 1'b0;
        char_count  = '0;
        glyph_ready = 1'b0;
        clear_mem();
        tick();
        tick();

        check_val("rst_select", int'(select), 0);
        check_val("rst_valid", int'(glyph_valid), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_overflow", int'(overflow), 0);
        reset = 1'b0;
        tick();

        // Glyph, space, glyph; first offer appears three cycles after start
        clear_mem();
        mem[0] = 6'd5; mem[1] = 6'd0; mem[2] = 6'd7;
        glyph_ready = 1'b1;
        pulse_start(3);
        check_val("t1_busy", int'(busy), 1);
        tick();
        tick();
        check_val("t1_lat_valid", int'(glyph_valid), 1);
        check_val("t1_lat_code", int'(glyph_code), 5);
        wait_done("t1", 200);
        check_val("t1_busy_at_done", int'(busy), 1);
        tick();
        check_val("t1_done_pulse", int'(done), 0);
        check_val("t1_busy_end", int'(busy), 0);
        check_val("t1_select", int'(select), 2);
        check_val("t1_count", accepted.size(), 2);
        check_val("t1_g0", int'(accepted[0]), int'(glyph(5, 0, 0)));
        check_val("t1_g1", int'(accepted[1]), int'(glyph(7, 2, 0)));

        // Newline moves the cursor without a glyph
        clear_mem();
        mem[0] = 6'd9; mem[1] = 6'd62; mem[2] = 6'd9;
        pulse_start(3);
        wait_done("t2", 200);
        check_val("t2_count", accepted.size(), 2);
        check_val("t2_g0", int'(accepted[0]), int'(glyph(9, 0, 0)));
        check_val("t2_g1", int'(accepted[1]), int'(glyph(9, 0, 1)));
        tick();

        // Seventeen glyphs wrap onto the second row
        clear_mem();
        for (int i = 0; i < 17; i++)
            mem[i] = 6'(i + 1);
        pulse_start(17);
        wait_done("t3", 500);
        check_val("t3_count", accepted.size(), 17);
        check_val("t3_g15", int'(accepted[15]), int'(glyph(16, 15, 0)));
        check_val("t3_g16", int'(accepted[16]), int'(glyph(17, 0, 1)));
        tick();

        // Drawer stalls for ten cycles; a stray draw_done arrives meanwhile
        clear_mem();
        mem[0] = 6'd20;
        glyph_ready = 1'b0;
        pulse_start(1);
        tick();
        tick();
        check_val("t4_valid", int'(glyph_valid), 1);
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3)
                stray_req++;
            tick();
            if (glyph_valid === 1'b1 && glyph_code === 6'd20 && glyph_col === 4'd0)
                stable++;
        end
        check_val("t4_stable", stable, 10);
        glyph_ready = 1'b1;
        wait_done("t4", 200);
        check_val("t4_count", accepted.size(), 1);
        tick();

        // End-of-text stops the walk at its slot
        clear_mem();
        mem[0] = 6'd4; mem[1] = 6'd63; mem[2] = 6'd4;
        pulse_start(3);
        wait_done("t5", 200);
        check_val("t5_count", accepted.size(), 1);
        check_val("t5_select", int'(select), 1);
        tick();

        // Empty buffer: done two cycles after start
        clear_mem();
        pulse_start(0);
        check_val("t5b_done_early", int'(done), 0);
        tick();
        check_val("t5b_done", int'(done), 1);
        check_val("t5b_count", accepted.size(), 0);
        tick();

        // Reset during OFFER, then a late draw_done
        clear_mem();
        mem[0] = 6'd30;
        glyph_ready = 1'b0;
        pulse_start(1);
        tick();
        tick();
        check_val("t6_valid_pre", int'(glyph_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t6_valid", int'(glyph_valid), 0);
        check_val("t6_code", int'(glyph_code), 0);
        check_val("t6_busy", int'(busy), 0);
        check_val("t6_col_row", int'({glyph_col, glyph_row}), 0);
        stray_req++;
        tick();
        tick();
        tick();
        check_val("t6_idle_busy", int'(busy), 0);
        check_val("t6_idle_done", int'(done), 0);
        check_val("t6_idle_valid", int'(glyph_valid), 0);
        glyph_ready = 1'b1;

        // Eight newlines overflow an eight-row page
        clear_mem();
        for (int i = 0; i < 8; i++)
            mem[i] = 6'd62;
        pulse_start(8);
        wait_done("t7", 300);
        check_val("t7_overflow", int'(overflow), 1);
        check_val("t7_count", accepted.size(), 0);
        tick();
        check_val("t7_sticky", int'(overflow), 1);
        pulse_start(0);
        check_val("t7_cleared", int'(overflow), 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
